nes_prg_mapper: RTL and testbench
=================================

# nes_prg_mapper

Parametrised CPU-side memory decoder and PRG bank mapper for the NES core, sitting between the 6502 bus and the program RAM/ROM macros. It mirrors internal work RAM and decodes optional cartridge PRG-RAM. It maps a configurable number of 16 KB PRG-ROM banks into $8000-$FFFF through an MMC1-style serial-loaded register file, so games larger than 32 KB run without per-game ROM muxing. It also exports the nametable mirroring mode to the PPU.

## Interface
- PRG_BANKS, 16, number of 16 KB PRG-ROM banks; power of two, 2..16.
- RAM_AW, 11, internal work-RAM address width; RAM mirrors every 2^RAM_AW bytes within $0000-$1FFF.
- PRGRAM_EN, 1, when 1, $6000-$7FFF decodes to 8 KB PRG-RAM.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  CPU bus select, active low.
- rd  in  1  CPU read strobe, active high.
- wr  in  1  CPU write strobe, active high.
- addr  in  16  CPU address.
- databus  inout  8  CPU data bus.
- ram_addr  out  RAM_AW  work-RAM address (addr[RAM_AW-1:0]).
- ram_rd / ram_wr  out  1  work-RAM strobes.
- ram_q  in  8  work-RAM read data, 1-cycle synchronous.
- prgram_addr  out  13  PRG-RAM address (addr[12:0]).
- prgram_rd / prgram_wr  out  1  PRG-RAM strobes.
- prgram_q  in  8  PRG-RAM read data, 1-cycle synchronous.
- rom_addr  out  $clog2(PRG_BANKS)+14  PRG-ROM byte address.
- rom_rd  out  1  PRG-ROM read strobe.
- rom_q  in  8  PRG-ROM read data, 1-cycle synchronous.
- mirror  out  2  nametable mirroring (ctrl[1:0]) to PPU.

## Operation
- Regions (only when !cs): RAM addr<$2000; PRG-RAM $6000-$7FFF when PRGRAM_EN=1 and prg_reg[4]=0; ROM addr>=$8000; everything else is unmapped.
- Strobes: ram_rd/ram_wr = rd/wr gated by RAM region. prgram_rd/prgram_wr = rd/wr gated by PRG-RAM region. rom_rd = rd gated by ROM region. CPU writes never reach the ROM.
- Mapper write event: the first cycle of wr & !cs & addr>=$8000 (rising edge of the qualified strobe). A write held for several cycles counts once.
- On a write event with databus[7]=1: shift ← 5'b10000 and ctrl[3:2] ← 2'b11. Other ctrl bits are unchanged.
- On a write event with databus[7]=0: shift ← {databus[0], shift[4:1]}. When the old shift[0]=1 (fifth bit), the value {databus[0], shift[4:1]} is loaded into a register chosen by addr[14:13]: 0 → ctrl, 1/2 → ignored (CHR, unused), 3 → prg_reg. In that case shift ← 5'b10000.
- Bank select, with b = prg_reg[3:0] and mode = ctrl[3:2]:
  - Mode 0/1 (32 KB): bank = {b[3:1], addr[14]}.
  - Mode 2: bank = 0 at $8000-$BFFF; bank = b at $C000-$FFFF.
  - Mode 3: bank = b at $8000-$BFFF; bank = PRG_BANKS-1 at $C000-$FFFF.
  - bank is masked to $clog2(PRG_BANKS) bits.
  - rom_addr = {bank, addr[13:0]}.
- Read path: a registered source select src ∈ {NONE, RAM, PRGRAM, ROM} is captured each cycle from the current decode.
- databus = the q selected by src when src≠NONE, rd=1 and cs=0; otherwise hi-Z. Unmapped reads are left to other bus agents.

## Timing
- Reset values: shift=5'b10000, ctrl=5'b01100 (mode 3, mirror 0), prg_reg=5'b00000, src=NONE, mirror=2'b00.
- All strobe and address outputs are combinational from the bus. databus is hi-Z during reset.
- Read latency is 1 cycle. Address and rd are presented in cycle N; databus is valid in cycle N+1 and stays valid while rd and the address are held. The CPU holds rd ≥2 cycles.
- Register updates take effect the cycle after the write event. A bank change affects rom_addr from that cycle.
- An rst_n assertion mid-serial-load discards the partial shift contents immediately (asynchronous reset).
- A reset write (databus[7]=1) on the same event that would have been a fifth bit takes priority: no register load occurs.
- Back-to-back write events with one idle cycle between them are each accepted.

## Test plan
- Reset, then read $FFFC with PRG_BANKS=16 → rom_addr=$3_FFFC and rom_rd=1; databus = rom_q one cycle later; mirror=0.
- Write $AA to $0000, read $1800 (RAM_AW=11) → ram_addr=$000 on both accesses; read returns $AA.
- Five writes to $E000 of bit0 = 1,0,1,0,0 (value 5), then read $8123 → rom_addr=$1_4123; read $C123 → rom_addr=$3_C123.
- Write $80 to $8000 after 3 serial bits, then five writes loading ctrl=5'b01011 → mirror=2'b11 and mode 2; read $8000 → rom_addr=$0_0000.
- Hold wr for 3 cycles on one $E000 write → shift advances exactly once.
- Set prg_reg[4]=1, then read $6000 → prgram_rd=0 and databus hi-Z. Read $4016 at any time → databus hi-Z.

Source files
------------

// File: rtl/nes_prg_mapper_if.sv
// CPU-side bus bundle (select, strobes, address) between the 6502 core and the PRG mapper.
// The data bus is bidirectional and is kept as a plain inout on the mapper.
interface nes_prg_mapper_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [15:0] addr;

    modport master (output cs, rd, wr, addr);
    modport slave  (input  cs, rd, wr, addr);
endinterface

// File: rtl/nes_prg_mapper.sv
// CPU memory decoder and MMC1-style PRG bank mapper: mirrors work RAM, decodes PRG-RAM,
// banks 16 KB PRG-ROM pages into $8000-$FFFF and exports nametable mirroring.
module nes_prg_mapper #(
    parameter int PRG_BANKS = 16,
    parameter int RAM_AW    = 11,
    parameter int PRGRAM_EN = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nes_prg_mapper_if.slave               bus,
    inout  wire  [7:0]                    databus,
    output logic [RAM_AW-1:0]             ram_addr,
    output logic                          ram_rd,
    output logic                          ram_wr,
    input  logic [7:0]                    ram_q,
    output logic [12:0]                   prgram_addr,
    output logic                          prgram_rd,
    output logic                          prgram_wr,
    input  logic [7:0]                    prgram_q,
    output logic [$clog2(PRG_BANKS)+13:0] rom_addr,
    output logic                          rom_rd,
    input  logic [7:0]                    rom_q,
    output logic [1:0]                    mirror
);
    localparam int BW = $clog2(PRG_BANKS);

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_RAM    = 2'd1,
        SRC_PRGRAM = 2'd2,
        SRC_ROM    = 2'd3
    } src_t;

    logic          in_ram_s;
    logic          in_prgram_s;
    logic          in_rom_s;
    logic          mw_s;
    logic          mw_d_r;
    logic          mw_event_s;
    logic [4:0]    shift_r;
    logic [4:0]    shift_next_s;
    // Only mirroring and PRG mode live here; the CHR mode bit has no consumer in a PRG-only mapper.
    logic [3:0]    ctrl_r;
    logic [4:0]    prg_reg_r;
    logic [BW-1:0] bank_s;
    src_t          src_r;
    logic [7:0]    rdata_s;
    logic          drive_s;

    // Address region decode for the selected bus cycle.
    always_comb begin
        in_ram_s    = 1'b0;
        in_prgram_s = 1'b0;
        in_rom_s    = 1'b0;
        if (!bus.cs) begin
            in_ram_s    = (bus.addr < 16'h2000);
            in_prgram_s = (PRGRAM_EN == 1) && (bus.addr[15:13] == 3'b011) && !prg_reg_r[4];
            in_rom_s    = bus.addr[15];
        end else begin
            in_ram_s    = 1'b0;
            in_prgram_s = 1'b0;
            in_rom_s    = 1'b0;
        end
    end

    assign ram_addr    = bus.addr[RAM_AW-1:0];
    assign ram_rd      = bus.rd & in_ram_s;
    assign ram_wr      = bus.wr & in_ram_s;
    assign prgram_addr = bus.addr[12:0];
    assign prgram_rd   = bus.rd & in_prgram_s;
    assign prgram_wr   = bus.wr & in_prgram_s;
    assign rom_rd      = bus.rd & in_rom_s;

    // A long write strobe must shift only once, so only its first cycle is an event.
    assign mw_s         = bus.wr & ~bus.cs & bus.addr[15];
    assign mw_event_s   = mw_s & ~mw_d_r;
    assign shift_next_s = {databus[0], shift_r[4:1]};

    // PRG bank selection from the current mode and the CPU half-window ($8000 or $C000).
    always_comb begin
        bank_s = {BW{1'b0}};
        case (ctrl_r[3:2])
            2'b10:   bank_s = bus.addr[14] ? BW'(prg_reg_r[3:0]) : {BW{1'b0}};
            2'b11:   bank_s = bus.addr[14] ? BW'(PRG_BANKS - 1) : BW'(prg_reg_r[3:0]);
            default: bank_s = BW'({prg_reg_r[3:1], bus.addr[14]});
        endcase
    end

    assign rom_addr = {bank_s, bus.addr[13:0]};
    assign mirror   = ctrl_r[1:0];

    // Serial shift register and the control / PRG bank registers it loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw_d_r    <= 1'b0;
            shift_r   <= 5'b10000;
            ctrl_r    <= 4'b1100;
            prg_reg_r <= 5'b00000;
        end else begin
            mw_d_r <= mw_s;
            if (mw_event_s) begin
                if (databus[7]) begin
                    shift_r     <= 5'b10000;
                    ctrl_r[3:2] <= 2'b11;
                end else if (shift_r[0]) begin
                    shift_r <= 5'b10000;
                    case (bus.addr[14:13])
                        2'b00:   ctrl_r    <= shift_next_s[3:0];
                        2'b11:   prg_reg_r <= shift_next_s;
                        default: ;
                    endcase
                end else begin
                    shift_r <= shift_next_s;
                end
            end
        end
    end

    // Remember which memory answers the current cycle; its data arrives one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_r <= SRC_NONE;
        end else if (in_ram_s) begin
            src_r <= SRC_RAM;
        end else if (in_prgram_s) begin
            src_r <= SRC_PRGRAM;
        end else if (in_rom_s) begin
            src_r <= SRC_ROM;
        end else begin
            src_r <= SRC_NONE;
        end
    end

    // Read-data mux and bus drive enable; unmapped reads leave the bus to other agents.
    always_comb begin
        rdata_s = 8'h00;
        case (src_r)
            SRC_RAM:    rdata_s = ram_q;
            SRC_PRGRAM: rdata_s = prgram_q;
            SRC_ROM:    rdata_s = rom_q;
            default:    rdata_s = 8'h00;
        endcase
        drive_s = rst_n && (src_r != SRC_NONE) && bus.rd && !bus.cs;
    end

    assign databus = drive_s ? rdata_s : 8'hzz;

endmodule

// File: tb/tb_nes_prg_mapper.sv
// Directed bench for nes_prg_mapper: decode, serial register loads, banking and read path.
module tb_nes_prg_mapper;
    localparam int PRG_BANKS = 16;
    localparam int RAM_AW    = 11;
    localparam int PRGRAM_EN = 1;
    localparam int RW        = $clog2(PRG_BANKS) + 14;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nes_prg_mapper_if bus_if ();

    wire  [7:0] databus;
    logic [7:0] tb_wdata;
    logic       tb_drive;
    assign databus = tb_drive ? tb_wdata : 8'hzz;

    // Undriven bus reads back as $FF so hi-Z is observable.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup (databus[gi]);
    end

    logic [RAM_AW-1:0] ram_addr;
    logic              ram_rd, ram_wr;
    logic [7:0]        ram_q;
    logic [12:0]       prgram_addr;
    logic              prgram_rd, prgram_wr;
    logic [7:0]        prgram_q;
    logic [RW-1:0]     rom_addr;
    logic              rom_rd;
    logic [7:0]        rom_q;
    logic [1:0]        mirror;

    nes_prg_mapper #(
        .PRG_BANKS (PRG_BANKS),
        .RAM_AW    (RAM_AW),
        .PRGRAM_EN (PRGRAM_EN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .databus     (databus),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_wr      (ram_wr),
        .ram_q       (ram_q),
        .prgram_addr (prgram_addr),
        .prgram_rd   (prgram_rd),
        .prgram_wr   (prgram_wr),
        .prgram_q    (prgram_q),
        .rom_addr    (rom_addr),
        .rom_rd      (rom_rd),
        .rom_q       (rom_q),
        .mirror      (mirror)
    );

    // Synchronous memory models with one cycle of read latency.
    logic [7:0] ram_mem    [0:(2**RAM_AW)-1];
    logic [7:0] prgram_mem [0:8191];
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= databus;
        if (ram_rd) ram_q <= ram_mem[ram_addr];
        if (prgram_wr) prgram_mem[prgram_addr] <= databus;
        if (prgram_rd) prgram_q <= prgram_mem[prgram_addr];
        if (rom_rd) rom_q <= rom_addr[7:0] ^ 8'h5A;
    end

    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        bus_if.cs   = 1'b0;
        bus_if.wr   = 1'b1;
        bus_if.addr = a;
        tb_wdata    = d;
        tb_drive    = 1'b1;
        repeat (hold) tick();
        bus_if.wr   = 1'b0;
        bus_if.cs   = 1'b1;
        tb_drive    = 1'b0;
        tick();
    endtask

    task automatic serial(input logic [15:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) cpu_write(a, {7'd0, v[i]}, 1);
    endtask

    task automatic read_begin(input logic [15:0] a);
        bus_if.cs   = 1'b0;
        bus_if.rd   = 1'b1;
        bus_if.addr = a;
        #1;
    endtask

    task automatic read_stop;
        bus_if.rd = 1'b0;
        bus_if.cs = 1'b1;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        bus_if.cs   = 1'b1;
        bus_if.rd   = 1'b0;
        bus_if.wr   = 1'b0;
        bus_if.addr = 16'h0000;
        tb_wdata    = 8'h00;
        tb_drive    = 1'b0;
        tick();
        read_begin(16'hFFFC);
        tick();
        check("reset_mirror", 32'(mirror), 32'h0);
        check("reset_bus_hiz", 32'(databus), 32'hFF);
        read_stop();
        rst_n = 1'b1;
        tick();

        // Reset vector fetch in mode 3 hits the last bank.
        read_begin(16'hFFFC);
        check("vec_rom_addr", 32'(rom_addr), 32'h3FFFC);
        check("vec_rom_rd", 32'(rom_rd), 32'h1);
        tick();
        check("vec_data", 32'(databus), 32'hA6);
        read_stop();

        // Work RAM mirroring.
        bus_if.cs = 1'b0; bus_if.wr = 1'b1; bus_if.addr = 16'h0000;
        tb_wdata = 8'hAA; tb_drive = 1'b1; #1;
        check("ram_wr_addr", 32'(ram_addr), 32'h000);
        check("ram_wr", 32'(ram_wr), 32'h1);
        tick();
        bus_if.wr = 1'b0; bus_if.cs = 1'b1; tb_drive = 1'b0; tick();
        read_begin(16'h1800);
        check("ram_rd_addr", 32'(ram_addr), 32'h000);
        check("ram_rd", 32'(ram_rd), 32'h1);
        tick();
        check("ram_data", 32'(databus), 32'hAA);
        read_stop();

        // prg_reg = 5, mode 3.
        serial(16'hE000, 5'b00101);
        read_begin(16'h8123);
        check("m3_lo_addr", 32'(rom_addr), 32'h14123);
        tick();
        check("m3_lo_data", 32'(databus), 32'h79);
        read_stop();
        read_begin(16'hC123);
        check("m3_hi_addr", 32'(rom_addr), 32'h3C123);
        read_stop();

        // Partial load aborted by reset write, then ctrl = 01011.
        cpu_write(16'h8000, 8'h01, 1);
        cpu_write(16'h8000, 8'h00, 1);
        cpu_write(16'h8000, 8'h01, 1);
        bus_if.cs = 1'b0; bus_if.wr = 1'b1; bus_if.addr = 16'h8000;
        tb_wdata = 8'h80; tb_drive = 1'b1; #1;
        check("rom_no_write", 32'(rom_rd), 32'h0);
        tick();
        bus_if.wr = 1'b0; bus_if.cs = 1'b1; tb_drive = 1'b0; tick();
        check("rstwr_mirror", 32'(mirror), 32'h0);
        serial(16'h8000, 5'b01011);
        check("ctrl_mirror", 32'(mirror), 32'h3);
        read_begin(16'h8000);
        check("m2_lo_addr", 32'(rom_addr), 32'h00000);
        read_stop();
        read_begin(16'hC000);
        check("m2_hi_addr", 32'(rom_addr), 32'h14000);
        read_stop();

        // Reset write on the fifth bit wins: no load, mode back to 3.
        for (int i = 0; i < 4; i++) cpu_write(16'hE000, 8'h01, 1);
        cpu_write(16'hE000, 8'h81, 1);
        read_begin(16'h8000);
        check("prio_addr", 32'(rom_addr), 32'h14000);
        read_stop();
        check("prio_mirror", 32'(mirror), 32'h3);

        // A write held for 3 cycles shifts once: prg_reg = 1.
        cpu_write(16'hE000, 8'h01, 3);
        for (int i = 0; i < 4; i++) cpu_write(16'hE000, 8'h00, 1);
        read_begin(16'h8000);
        check("hold_addr", 32'(rom_addr), 32'h04000);
        read_stop();

        // PRG-RAM enabled.
        cpu_write(16'h6010, 8'h3C, 1);
        read_begin(16'h6010);
        check("pram_rd", 32'(prgram_rd), 32'h1);
        check("pram_addr", 32'(prgram_addr), 32'h0010);
        tick();
        check("pram_data", 32'(databus), 32'h3C);
        read_stop();

        // PRG-RAM disabled by prg_reg[4]; unmapped read.
        serial(16'hE000, 5'b10000);
        read_begin(16'h6000);
        check("pram_off_rd", 32'(prgram_rd), 32'h0);
        tick();
        check("pram_off_hiz", 32'(databus), 32'hFF);
        read_stop();
        read_begin(16'h4016);
        check("unmap_rom_rd", 32'(rom_rd), 32'h0);
        check("unmap_ram_rd", 32'(ram_rd), 32'h0);
        tick();
        check("unmap_hiz", 32'(databus), 32'hFF);
        read_stop();

        // 32 KB mode with prg_reg = 2.
        serial(16'hE000, 5'b00010);
        serial(16'h8000, 5'b00010);
        check("m0_mirror", 32'(mirror), 32'h2);
        read_begin(16'h8123);
        check("m0_lo_addr", 32'(rom_addr), 32'h08123);
        read_stop();
        read_begin(16'hC123);
        check("m0_hi_addr", 32'(rom_addr), 32'h0C123);
        read_stop();

        // Asynchronous reset in the middle of a serial load.
        cpu_write(16'hE000, 8'h01, 1);
        cpu_write(16'hE000, 8'h01, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_mirror", 32'(mirror), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        serial(16'hE000, 5'b00010);
        read_begin(16'h8000);
        check("async_prg_addr", 32'(rom_addr), 32'h08000);
        read_stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
